fa_exhaustive_checker: RTL and testbench



---
 rtl/fa_exhaustive_checker.sv | 137 +++++++++++++
 tb/tb_fa_exhaustive_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fa_exhaustive_checker.sv
// On-chip self-test for a 1-bit full adder: sweeps all eight {a,b,cin}
// vectors, holds each for SETTLE_CYCLES before sampling sum/cout, and
// records the mismatch count and the first failing vector.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, drive vector parked at 0
// SETTLE | current vector held while the adder outputs settle
// CHECK  | one cycle: compare sum/cout against golden, advance vector
// DONE   | sweep finished, results held until start or reset
module fa_exhaustive_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    output logic       cin_o,
    input  logic       sum_i,
    input  logic       cout_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("fa_exhaustive_checker: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] vec, vec_nxt;
    logic [3:0] settle_cnt, settle_cnt_nxt;
    logic [3:0] err_nxt;
    logic [2:0] ffv_nxt;
    logic       ffvalid_nxt;
    logic       busy_nxt, done_nxt, pass_nxt;
    logic       exp_sum, exp_cout, mismatch;

    // Golden adder for the vector currently driven; case inequality so
    // an undriven or unknown response is treated as a failure.
    always_comb begin
        exp_sum  = vec[2] ^ vec[1] ^ vec[0];
        exp_cout = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
        mismatch = (sum_i !== exp_sum) || (cout_i !== exp_cout);
    end

    // Next-state and next-result logic; status flags are derived from the
    // next state so they are registered alongside it.
    always_comb begin
        state_nxt      = state;
        vec_nxt        = vec;
        settle_cnt_nxt = settle_cnt;
        err_nxt        = err_count;
        ffv_nxt        = first_fail_vec;
        ffvalid_nxt    = first_fail_valid;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    vec_nxt        = 3'd0;
                    settle_cnt_nxt = 4'd0;
                    err_nxt        = 4'd0;
                    ffv_nxt        = 3'd0;
                    ffvalid_nxt    = 1'b0;
                    state_nxt      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CHECK;
                end else begin
                    settle_cnt_nxt = settle_cnt + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_nxt = err_count + 4'd1;
                    if (!first_fail_valid) begin
                        ffv_nxt     = vec;
                        ffvalid_nxt = 1'b1;
                    end
                end
                if (vec == 3'd7) begin
                    state_nxt = DONE;
                end else begin
                    vec_nxt        = vec + 3'd1;
                    settle_cnt_nxt = 4'd0;
                    state_nxt      = SETTLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == SETTLE) || (state_nxt == CHECK);
        done_nxt = (state_nxt == DONE);
        pass_nxt = done_nxt && (err_nxt == 4'd0);
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= 3'd0;
            settle_cnt       <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 4'd0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_nxt;
            vec              <= vec_nxt;
            settle_cnt       <= settle_cnt_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
            pass             <= pass_nxt;
            err_count        <= err_nxt;
            first_fail_vec   <= ffv_nxt;
            first_fail_valid <= ffvalid_nxt;
        end
    end

    assign {a_o, b_o, cin_o} = vec;

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// Bench for fa_exhaustive_checker: two instances (settle 2 and settle 1)
// each beside a behavioural adder whose fault mode is selectable.
module tb_fa_exhaustive_checker;

    localparam int S0 = 2;
    localparam int S1 = 1;

    typedef struct {
        logic [3:0] err;
        logic [2:0] ffv;
        logic       ffvalid;
        logic       pass;
        int         cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start   [2];
    logic       a       [2];
    logic       b       [2];
    logic       cin     [2];
    logic       sum     [2];
    logic       cout    [2];
    logic       busy    [2];
    logic       done    [2];
    logic       pass    [2];
    logic [3:0] err     [2];
    logic [2:0] ffv     [2];
    logic       ffvalid [2];

    int   mode = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Behavioural adder: 0 = correct, 1 = cout stuck at 0, 2 = sum inverted.
    function automatic logic [1:0] fa_model(input int m, input logic x, input logic y, input logic z);
        logic s, c;
        s = x ^ y ^ z;
        c = (x & y) | (x & z) | (y & z);
        if (m == 1) c = 1'b0;
        if (m == 2) s = ~s;
        return {s, c};
    endfunction

    assign {sum[0], cout[0]} = fa_model(mode, a[0], b[0], cin[0]);
    assign {sum[1], cout[1]} = fa_model(mode, a[1], b[1], cin[1]);

    fa_exhaustive_checker #(.SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .a_o(a[0]), .b_o(b[0]), .cin_o(cin[0]),
        .sum_i(sum[0]), .cout_i(cout[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err[0]), .first_fail_vec(ffv[0]), .first_fail_valid(ffvalid[0])
    );

    fa_exhaustive_checker #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .a_o(a[1]), .b_o(b[1]), .cin_o(cin[1]),
        .sum_i(sum[1]), .cout_i(cout[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err[1]), .first_fail_vec(ffv[1]), .first_fail_valid(ffvalid[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] drv(input int d);
        return {a[d], b[d], cin[d]};
    endfunction

    // Expected sweep outcome for the current fault mode and settle length.
    task automatic push_expected(input int s);
        exp_t       e;
        logic [1:0] g, m;
        logic [2:0] v;
        e.err = 4'd0; e.ffv = 3'd0; e.ffvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            g = {v[2] ^ v[1] ^ v[0], (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])};
            m = fa_model(mode, v[2], v[1], v[0]);
            if (m !== g) begin
                e.err = e.err + 4'd1;
                if (!e.ffvalid) begin
                    e.ffv = v;
                    e.ffvalid = 1'b1;
                end
            end
        end
        e.pass   = (e.err == 4'd0);
        e.cycles = 8 * (s + 1);
        sb.push_back(e);
    endtask

    task automatic pulse_start(input int d, input int s, input bit expect_result);
        if (expect_result) push_expected(s);
        start[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    // Called on the first negedge after the start edge; follows the sweep,
    // optionally pokes start at cycle poke_at, then scores the result.
    task automatic finish_sweep(input int d, input int s, input int poke_at);
        exp_t e;
        int   k;
        k = 1;
        while (!done[d] && k <= 200) begin
            check_val("busy", 32'(busy[d]), 32'd1);
            check_val("drive_vec", 32'(drv(d)), 32'((k - 1) / (s + 1)));
            start[d] = (k == poke_at);
            @(negedge clk);
            k++;
        end
        start[d] = 1'b0;
        check_val("done_reached", 32'(done[d]), 32'd1);
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check_val("latency", 32'(k - 1), 32'(e.cycles));
            check_val("err_count", 32'(err[d]), 32'(e.err));
            check_val("first_fail_vec", 32'(ffv[d]), 32'(e.ffv));
            check_val("first_fail_valid", 32'(ffvalid[d]), 32'(e.ffvalid));
            check_val("pass", 32'(pass[d]), 32'(e.pass));
            check_val("busy_after", 32'(busy[d]), 32'd0);
            check_val("done_vec7", 32'(drv(d)), 32'd7);
        end
    endtask

    task automatic reset_check(input int d);
        check_val("rst_drive", 32'(drv(d)), 32'd0);
        check_val("rst_busy", 32'(busy[d]), 32'd0);
        check_val("rst_done", 32'(done[d]), 32'd0);
        check_val("rst_pass", 32'(pass[d]), 32'd0);
        check_val("rst_err", 32'(err[d]), 32'd0);
        check_val("rst_ffv", 32'(ffv[d]), 32'd0);
        check_val("rst_ffvalid", 32'(ffvalid[d]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        reset_check(0);
        reset_check(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct adder, then cout stuck at 0, then sum inverted.
        mode = 0; pulse_start(0, S0, 1'b1); finish_sweep(0, S0, 0);
        mode = 1; pulse_start(0, S0, 1'b1); finish_sweep(0, S0, 0);
        mode = 2; pulse_start(0, S0, 1'b1); finish_sweep(0, S0, 0);

        // Restart from DONE clears results at once; a start poked mid-sweep is ignored.
        mode = 0;
        pulse_start(0, S0, 1'b1);
        check_val("restart_err", 32'(err[0]), 32'd0);
        check_val("restart_ffvalid", 32'(ffvalid[0]), 32'd0);
        check_val("restart_ffv", 32'(ffv[0]), 32'd0);
        check_val("restart_done", 32'(done[0]), 32'd0);
        check_val("restart_pass", 32'(pass[0]), 32'd0);
        finish_sweep(0, S0, 10);

        // Reset mid-sweep at vector 4, then a clean sweep.
        pulse_start(0, S0, 1'b0);
        for (int i = 0; i < 100 && drv(0) != 3'd4; i++) @(negedge clk);
        check_val("reach_vec4", 32'(drv(0)), 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_check(0);
        pulse_start(0, S0, 1'b1);
        finish_sweep(0, S0, 0);

        // Minimum settle length.
        pulse_start(1, S1, 1'b1);
        finish_sweep(1, S1, 0);

        check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
